// File: rtl/fifo_drain_packer_if.sv
// Packed output beat stream of fifo_drain_packer.
// Lane 0 of m_data holds the oldest word. m_keep marks the valid lanes.
interface fifo_drain_packer_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int PACK_RATIO = 4
);
  localparam int OUT_WIDTH = FIFO_WIDTH * PACK_RATIO;

  logic [OUT_WIDTH-1:0]  m_data;
  logic [PACK_RATIO-1:0] m_keep;
  logic                  m_last;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, m_keep, m_last, m_valid, input m_ready);
  modport slave  (input m_data, m_keep, m_last, m_valid, output m_ready);
endinterface

// File: rtl/fifo_drain_packer.sv
// Drains a synchronous FIFO, which has a 1-cycle read latency.
// Packs PACK_RATIO words into one wide beat. Flush emits a partial beat with a lane mask.
module fifo_drain_packer #(
  parameter int FIFO_WIDTH = 16,
  parameter int PACK_RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  err_underflow,
  output logic [15:0]           beat_count,
  fifo_drain_packer_if.master   m
);
  localparam int OUT_WIDTH = FIFO_WIDTH * PACK_RATIO;
  localparam int CNT_W     = $clog2(PACK_RATIO + 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(PACK_RATIO);
  localparam logic [CNT_W:0]   RATIO_EXT = (CNT_W + 1)'(PACK_RATIO);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] FLUSH_WAIT = 2'd1;
  localparam logic [1:0] FLUSH_EMIT = 2'd2;

  logic [1:0]            state;
  logic [OUT_WIDTH-1:0]  acc;
  logic [CNT_W-1:0]      lane_cnt;
  logic                  inflight;
  logic                  acc_full;
  logic                  out_free;
  logic                  accept;
  logic                  full_xfer;
  logic                  emit;
  logic [CNT_W:0]        fill;
  logic [PACK_RATIO-1:0] part_keep;

  always_comb begin
    acc_full  = (lane_cnt == FULL);
    fill      = {1'b0, lane_cnt} + {{CNT_W{1'b0}}, inflight};
    out_free  = !m.m_valid || m.m_ready;
    accept    = m.m_valid && m.m_ready;
    // A full accumulator still drains normally while a flush waits for its in-flight word.
    full_xfer = (state != FLUSH_EMIT) && acc_full && out_free;
    emit      = (state == FLUSH_EMIT) && out_free;
    fifo_rd_en = (state == RUN) && !rst && !fifo_empty && (fill < RATIO_EXT);
    part_keep = '0;
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      part_keep[i] = (CNT_W'(i) < lane_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      acc           <= '0;
      lane_cnt      <= '0;
      inflight      <= 1'b0;
      m.m_data      <= '0;
      m.m_keep      <= '0;
      m.m_last      <= 1'b0;
      m.m_valid     <= 1'b0;
      err_underflow <= 1'b0;
      beat_count    <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight && fifo_underflow) begin
        err_underflow <= 1'b1;
      end
      if (accept) begin
        beat_count <= beat_count + 16'd1;
      end

      // inflight is never set while full or emitting, so capture cannot collide with a clear.
      if (full_xfer || emit) begin
        acc      <= '0;
        lane_cnt <= '0;
      end else if (inflight) begin
        for (int unsigned i = 0; i < PACK_RATIO; i++) begin
          if (lane_cnt == CNT_W'(i)) begin
            acc[i*FIFO_WIDTH +: FIFO_WIDTH] <= fifo_data_out;
          end
        end
        lane_cnt <= lane_cnt + CNT_W'(1);
      end

      if (full_xfer) begin
        m.m_data  <= acc;
        m.m_keep  <= '1;
        m.m_last  <= 1'b0;
        m.m_valid <= 1'b1;
      end else if (emit) begin
        m.m_data  <= acc;
        m.m_keep  <= part_keep;
        m.m_last  <= 1'b1;
        m.m_valid <= 1'b1;
      end else if (accept) begin
        m.m_valid <= 1'b0;
      end

      case (state)
        RUN: begin
          if (flush) state <= FLUSH_WAIT;
        end
        FLUSH_WAIT: begin
          if (!inflight && !acc_full) begin
            state <= (lane_cnt != '0) ? FLUSH_EMIT : RUN;
          end
        end
        FLUSH_EMIT: begin
          if (out_free) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_drain_packer.sv
// Bench for fifo_drain_packer. A queue models the FIFO.
// A word-order reference model checks every accepted beat.
module tb_fifo_drain_packer;
  localparam int FW    = 16;
  localparam int PR    = 4;
  localparam int OUT_W = FW * PR;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [FW-1:0] fifo_data_out;
  logic          fifo_underflow;
  logic          fifo_rd_en;
  logic          flush;
  logic          err_underflow;
  logic [15:0]   beat_count;

  fifo_drain_packer_if #(.FIFO_WIDTH(FW), .PACK_RATIO(PR)) s ();

  fifo_drain_packer #(.FIFO_WIDTH(FW), .PACK_RATIO(PR)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en), .flush(flush),
    .err_underflow(err_underflow), .beat_count(beat_count), .m(s)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_bc  = 0;
  logic [FW-1:0] fifo_q[$];
  logic [FW-1:0] ref_q[$];

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO with a registered read port
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data_out <= fifo_q.pop_front();
      if (fifo_q.size() == 0) fifo_empty <= 1'b1;
    end
  end

  task automatic push(input logic [FW-1:0] w);
    fifo_q.push_back(w);
    ref_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [OUT_W-1:0] peek_pack(input int n);
    logic [OUT_W-1:0] v = '0;
    for (int i = 0; i < n; i++) v[i*FW +: FW] = ref_q[i];
    return v;
  endfunction

  task automatic wait_drain(input int budget, input string tag);
    int c = 0;
    while ((ref_q.size() != 0 || s.m_valid) && c < budget) begin
      step(1);
      c++;
    end
    check(tag, OUT_W'(c < budget), OUT_W'(1));
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int c = 0;
    while (!s.m_valid && c < budget) begin
      step(1);
      c++;
    end
    check(tag, OUT_W'(c < budget), OUT_W'(1));
  endtask

  // Beat monitor: each accepted beat carries the oldest words of the
  // reference stream. A beat with fewer words than PR must be a flush beat.
  logic             hold_prev = 1'b0;
  logic [OUT_W-1:0] hold_data;
  logic [PR:0]      hold_kl;
  int               mon_n;
  logic [PR-1:0]    mon_keep;
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en) check("rd_while_empty", OUT_W'(fifo_empty), OUT_W'(0));
      if (hold_prev) begin
        check("hold_valid", OUT_W'(s.m_valid), OUT_W'(1));
        check("hold_data", s.m_data, hold_data);
        check("hold_keep_last", OUT_W'({s.m_keep, s.m_last}), OUT_W'(hold_kl));
      end
      if (s.m_valid && s.m_ready) begin
        mon_n = (ref_q.size() < PR) ? ref_q.size() : PR;
        mon_keep = '0;
        for (int i = 0; i < mon_n; i++) mon_keep[i] = 1'b1;
        check("beat_data", s.m_data, peek_pack(mon_n));
        check("beat_keep", OUT_W'(s.m_keep), OUT_W'(mon_keep));
        check("beat_last", OUT_W'(s.m_last), OUT_W'(mon_n < PR));
        repeat (mon_n) void'(ref_q.pop_front());
      end
    end
    hold_prev = s.m_valid && !s.m_ready && !rst;
    hold_data = s.m_data;
    hold_kl   = {s.m_keep, s.m_last};
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_words;
    rst = 1'b1; flush = 1'b0; fifo_underflow = 1'b0; s.m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_data_out = '0;
    step(2);
    push(16'h0001);
    step(1);
    check("rst_m_valid", OUT_W'(s.m_valid), OUT_W'(0));
    check("rst_m_data", s.m_data, OUT_W'(0));
    check("rst_m_keep_last", OUT_W'({s.m_keep, s.m_last}), OUT_W'(0));
    check("rst_rd_en_forced", OUT_W'(fifo_rd_en), OUT_W'(0));
    check("rst_err", OUT_W'(err_underflow), OUT_W'(0));
    check("rst_beat_count", OUT_W'(beat_count), OUT_W'(0));

    // Eight sequential words produce two full beats. The first beat appears on the 6th edge.
    for (int i = 2; i <= 8; i++) push(FW'(i));
    s.m_ready = 1'b1;
    rst = 1'b0;
    step(5);
    check("latency_not_yet", OUT_W'(s.m_valid), OUT_W'(0));
    step(1);
    check("latency_valid", OUT_W'(s.m_valid), OUT_W'(1));
    check("first_beat_const", s.m_data, 64'h0004_0003_0002_0001);
    check("first_beat_keep", OUT_W'(s.m_keep), OUT_W'(4'hF));
    wait_drain(100, "drain_two_beats");
    exp_bc += 2;
    check("bc_two", OUT_W'(beat_count), OUT_W'(exp_bc));

    // Partial flush of three words
    push(16'h000A); push(16'h000B); push(16'h000C);
    step(8);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_valid(10, "flush_partial_timeout");
    check("flush_data_const", s.m_data, 64'h0000_000C_000B_000A);
    check("flush_keep", OUT_W'(s.m_keep), OUT_W'(4'b0111));
    check("flush_last", OUT_W'(s.m_last), OUT_W'(1));
    wait_drain(20, "drain_flush");
    exp_bc += 1;
    check("bc_flush", OUT_W'(beat_count), OUT_W'(exp_bc));

    // Empty flush emits no beat. Reads resume once the FSM is back in RUN.
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    for (int i = 0; i < PR; i++) push(FW'($urandom));
    #1;
    check("empty_flush_rd_blocked", OUT_W'(fifo_rd_en), OUT_W'(0));
    step(1);
    check("empty_flush_rd_resume", OUT_W'(fifo_rd_en), OUT_W'(1));
    check("empty_flush_no_beat", OUT_W'(s.m_valid), OUT_W'(0));
    check("empty_flush_bc", OUT_W'(beat_count), OUT_W'(exp_bc));
    wait_drain(100, "drain_after_empty_flush");
    exp_bc += 1;

    // Backpressure: the first beat is held, the second is accumulated, and 4 words stay in the FIFO.
    s.m_ready = 1'b0;
    for (int i = 0; i < 3 * PR; i++) push(FW'($urandom));
    step(20);
    check("stall_rd_en", OUT_W'(fifo_rd_en), OUT_W'(0));
    check("stall_fifo_level", OUT_W'(fifo_q.size()), OUT_W'(4));
    check("stall_valid", OUT_W'(s.m_valid), OUT_W'(1));
    check("stall_data", s.m_data, peek_pack(PR));
    s.m_ready = 1'b1;
    wait_drain(200, "drain_stall");
    exp_bc += 3;
    check("bc_stall", OUT_W'(beat_count), OUT_W'(exp_bc));

    // Underflow in the capture cycle is sticky. The word is still packed.
    check("err_before", OUT_W'(err_underflow), OUT_W'(0));
    push(16'hBEEF);
    fifo_underflow = 1'b1;
    step(2);
    fifo_underflow = 1'b0;
    check("err_set", OUT_W'(err_underflow), OUT_W'(1));
    push(16'h1111); push(16'h2222); push(16'h3333);
    wait_drain(100, "drain_underflow");
    exp_bc += 1;
    check("err_sticky", OUT_W'(err_underflow), OUT_W'(1));

    // Randomized pushes and backpressure
    n_words = 0;
    for (int c = 0; c < 400; c++) begin
      s.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        push(FW'($urandom));
        n_words++;
      end
      step(1);
    end
    while (n_words % PR != 0) begin
      push(FW'($urandom));
      n_words++;
    end
    s.m_ready = 1'b1;
    wait_drain(2000, "drain_random");
    exp_bc += n_words / PR;
    check("bc_random", OUT_W'(beat_count), OUT_W'(exp_bc & 32'hFFFF));

    // Reset with a pending beat and 2 captured lanes
    s.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(FW'($urandom));
    step(15);
    check("pre_reset_valid", OUT_W'(s.m_valid), OUT_W'(1));
    rst = 1'b1;
    step(1);
    check("mid_rst_valid", OUT_W'(s.m_valid), OUT_W'(0));
    check("mid_rst_data", s.m_data, OUT_W'(0));
    check("mid_rst_keep_last", OUT_W'({s.m_keep, s.m_last}), OUT_W'(0));
    check("mid_rst_err", OUT_W'(err_underflow), OUT_W'(0));
    check("mid_rst_bc", OUT_W'(beat_count), OUT_W'(0));
    check("mid_rst_rd_en", OUT_W'(fifo_rd_en), OUT_W'(0));
    ref_q.delete();
    fifo_q.delete();
    fifo_empty = 1'b1;
    rst = 1'b0;
    s.m_ready = 1'b1;
    push(16'h0021); push(16'h0022); push(16'h0023); push(16'h0024);
    wait_valid(20, "post_reset_timeout");
    check("post_reset_lane0", s.m_data, 64'h0024_0023_0022_0021);
    wait_drain(20, "drain_post_reset");
    check("post_reset_bc", OUT_W'(beat_count), OUT_W'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
